regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (rd_addr/rd_data/rd_wren) between
//  two writeback sources: port A (ALU/execute result) and port B (load/late result).

---
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus shared by both result sources and the register-file port.
// The master side is the requesters plus the regfile; the slave side is the arbiter.
interface regfile_wb_arbiter_if;
    logic        a_valid_i;
    logic [4:0]  a_addr_i;
    logic [31:0] a_data_i;
    logic        a_ready_o;
    logic        b_valid_i;
    logic [4:0]  b_addr_i;
    logic [31:0] b_data_i;
    logic        b_ready_o;
    logic        rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        force_b_o;

    modport master (
        output a_valid_i, a_addr_i, a_data_i,
        output b_valid_i, b_addr_i, b_data_i,
        input  a_ready_o, b_ready_o,
        input  rd_wren_o, rd_addr_o, rd_data_o,
        input  force_b_o
    );

    modport slave (
        input  a_valid_i, a_addr_i, a_data_i,
        input  b_valid_i, b_addr_i, b_data_i,
        output a_ready_o, b_ready_o,
        output rd_wren_o, rd_addr_o, rd_data_o,
        output force_b_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the single regfile write port.
// Port A wins by default; port B is forced through after MAX_WAIT straight losses.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 2
) (
    input logic clk_i,
    input logic rst_i,
    regfile_wb_arbiter_if.slave bus
);

    typedef enum logic {
        PRI_A,
        FORCE_B
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             a_rdy;
    logic             b_rdy;
    logic             gnt;
    logic [4:0]       gnt_addr;
    logic [31:0]      gnt_data;
    logic             wren_q;
    logic [4:0]       addr_q;
    logic [31:0]      data_q;

    assign cnt_inc = cnt_q + ONE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PRI_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_rdy   = 1'b0;
        b_rdy   = 1'b0;
        unique case (state_q)
            PRI_A: begin
                if (bus.a_valid_i) begin
                    a_rdy = 1'b1;
                    if (bus.b_valid_i) begin
                        // B lost this cycle; counter saturates instead of wrapping
                        cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_inc;
                        if (cnt_inc == MAX_CNT)
                            state_d = FORCE_B;
                    end else begin
                        cnt_d = '0;
                    end
                end else if (bus.b_valid_i) begin
                    b_rdy = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = '0;
                end
            end
            FORCE_B: begin
                // Leave either way: B granted, or B withdrew (no grant)
                b_rdy   = bus.b_valid_i;
                state_d = PRI_A;
                cnt_d   = '0;
            end
            default: begin
                state_d = PRI_A;
                cnt_d   = '0;
            end
        endcase
    end

    assign gnt      = a_rdy | b_rdy;
    assign gnt_addr = a_rdy ? bus.a_addr_i : bus.b_addr_i;
    assign gnt_data = a_rdy ? bus.a_data_i : bus.b_data_i;

    // x0 writes are accepted but never reach the regfile
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wren_q <= gnt && (gnt_addr != 5'd0);
            if (gnt) begin
                addr_q <= gnt_addr;
                data_q <= gnt_data;
            end
        end
    end

    assign bus.a_ready_o = a_rdy;
    assign bus.b_ready_o = b_rdy;
    assign bus.rd_wren_o = wren_q;
    assign bus.rd_addr_o = addr_q;
    assign bus.rd_data_o = data_q;
    assign bus.force_b_o = (state_q == FORCE_B);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single-source,
// starvation guard, x0 suppression and counter restart.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic rst_i;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(
        .MAX_WAIT(3),
        .CNT_W   (2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa,
                         input logic [31:0] ad, input logic bv,
                         input logic [4:0] ba, input logic [31:0] bd);
        bus.a_valid_i = av;
        bus.a_addr_i  = aa;
        bus.a_data_i  = ad;
        bus.b_valid_i = bv;
        bus.b_addr_i  = ba;
        bus.b_data_i  = bd;
    endtask

    // Check handshake mid-cycle, then advance past the next rising edge
    task automatic cyc(input string tag, input logic ear,
                       input logic ebr, input logic efb);
        @(negedge clk);
        chk({tag, ".a_rdy"}, bus.a_ready_o, ear);
        chk({tag, ".b_rdy"}, bus.b_ready_o, ebr);
        chk({tag, ".force"}, bus.force_b_o, efb);
        chk({tag, ".excl"}, bus.a_ready_o & bus.b_ready_o, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic out(input string tag, input logic ew,
                       input logic [4:0] ea, input logic [31:0] ed);
        chk({tag, ".wren"}, bus.rd_wren_o, ew);
        chk({tag, ".addr"}, bus.rd_addr_o, ea);
        chk({tag, ".data"}, bus.rd_data_o, ed);
    endtask

    initial begin
        logic [4:0] a_nxt;
        logic       eb;
        rst_i = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        out("rst0", 1'b0, 5'd0, 32'd0);
        chk("rst0.force", bus.force_b_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // 1: async reset mid-stream
        drive(1'b1, 5'd7, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
        cyc("t1", 1'b1, 1'b0, 1'b0);
        out("t1.pre", 1'b1, 5'd7, 32'h0000_1234);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        rst_i = 1'b1;
        #1;
        out("t1.rst", 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        chk("t1.force", bus.force_b_o, 1'b0);
        @(posedge clk);
        #1;

        // 2: A only
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        cyc("t2", 1'b1, 1'b0, 1'b0);
        out("t2", 1'b1, 5'd5, 32'hDEAD_BEEF);

        // 3: both valid continuously -> A,A,A,B,A,A,A,B
        a_nxt = 5'd1;
        for (int k = 0; k < 8; k++) begin
            eb = (k % 4 == 3);
            drive(1'b1, a_nxt, {27'd0, a_nxt}, 1'b1, 5'd9, 32'h0000_0B0B);
            cyc($sformatf("t3.%0d", k), !eb, eb, eb);
            if (eb) begin
                out($sformatf("t3.%0d", k), 1'b1, 5'd9, 32'h0000_0B0B);
            end else begin
                out($sformatf("t3.%0d", k), 1'b1, a_nxt, {27'd0, a_nxt});
                a_nxt = a_nxt + 5'd1;
            end
        end

        // 4: B only; counter must be 0 afterwards
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'd1);
        cyc("t4", 1'b0, 1'b1, 1'b0);
        out("t4", 1'b1, 5'd31, 32'd1);
        for (int k = 0; k < 4; k++) begin
            eb = (k == 3);
            drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
            cyc($sformatf("t4.cnt%0d", k), !eb, eb, eb);
        end

        // 5: x0 write accepted but suppressed
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        cyc("t5", 1'b1, 1'b0, 1'b0);
        chk("t5.wren", bus.rd_wren_o, 1'b0);

        // Idle: no grant -> wren drops, addr/data hold
        drive(1'b1, 5'd12, 32'hC0FFEE, 1'b0, 5'd0, 32'd0);
        cyc("idle.pre", 1'b1, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cyc("idle", 1'b0, 1'b0, 1'b0);
        out("idle", 1'b0, 5'd12, 32'hC0FFEE);

        // 6: two losses, B drops, then three more losses before force
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd6, 32'h6);
        cyc("t6.l1", 1'b1, 1'b0, 1'b0);
        cyc("t6.l2", 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd6, 32'h6);
        cyc("t6.drop", 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd6, 32'h6);
        cyc("t6.r1", 1'b1, 1'b0, 1'b0);
        cyc("t6.r2", 1'b1, 1'b0, 1'b0);
        cyc("t6.r3", 1'b1, 1'b0, 1'b0);
        cyc("t6.force", 1'b0, 1'b1, 1'b1);
        out("t6.force", 1'b1, 5'd6, 32'h6);

        // FORCE_B entered, then B withdraws: no grant, back to PRI_A
        cyc("t7.l1", 1'b1, 1'b0, 1'b0);
        cyc("t7.l2", 1'b1, 1'b0, 1'b0);
        cyc("t7.l3", 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd6, 32'h6);
        cyc("t7.viol", 1'b0, 1'b0, 1'b1);
        chk("t7.viol.wren", bus.rd_wren_o, 1'b0);
        cyc("t7.back", 1'b1, 1'b0, 1'b0);
        out("t7.back", 1'b1, 5'd2, 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
